// File: rtl/axis_ramp_ctrl.sv
// Multi-channel virtual analog axis: rate-limited digital ramp or mapped analog stick per channel.
// Optional AXIS_RAMP_ACCEL_EN: step grows to 4 after 32 consecutive same-direction ticks.

module axis_ramp_lane #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 254,
    parameter int REST_VAL = 0,
    parameter int INVERT   = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             tick,
    input  logic             inc,
    input  logic             dec,
    input  logic             spring,
    input  logic             use_analog,
    input  logic [WIDTH-1:0] analog,
    output logic [WIDTH-1:0] value
);
    localparam logic [WIDTH:0]   HALF   = (WIDTH+1)'(1 << (WIDTH-1));
    localparam logic [WIDTH:0]   FULL   = (WIDTH+1)'((1 << WIDTH) - 1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] REST_W = WIDTH'(REST_VAL);

    logic [WIDTH-1:0] acc, acc_nxt, step, u_clamp;
    logic [WIDTH:0]   u_raw, u_map, up_sum;

`ifdef AXIS_RAMP_ACCEL_EN
    logic [5:0] hold_cnt;
    logic       hold_dir;

    assign step = (hold_cnt >= 6'd32) ? WIDTH'(4) : WIDTH'(1);

    // hold_cnt = consecutive prior ticks with the same single direction held
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hold_cnt <= '0;
            hold_dir <= 1'b0;
        end else if (use_analog) begin
            hold_cnt <= '0;
        end else if (tick) begin
            if (inc ^ dec) begin
                if (hold_cnt != '0 && hold_dir == inc) begin
                    if (hold_cnt < 6'd32)
                        hold_cnt <= hold_cnt + 6'd1;
                end else begin
                    hold_cnt <= 6'd1;
                end
                hold_dir <= inc;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign step = WIDTH'(1);
`endif

    always_comb begin
        u_raw   = {analog[WIDTH-1], analog} + HALF;
        u_map   = (INVERT != 0) ? (FULL - u_raw) : u_raw;
        u_clamp = (u_map > {1'b0, MAX_W}) ? MAX_W : u_map[WIDTH-1:0];
        up_sum  = {1'b0, acc} + {1'b0, step};
        acc_nxt = acc;
        // analog mode keeps acc tracking the stick so ramp mode resumes bumplessly
        if (use_analog) begin
            acc_nxt = u_clamp;
        end else if (tick) begin
            if (inc && !dec)
                acc_nxt = (up_sum > {1'b0, MAX_W}) ? MAX_W : up_sum[WIDTH-1:0];
            else if (dec && !inc)
                acc_nxt = (acc < step) ? '0 : acc - step;
            else if (!inc && !dec && spring) begin
                if (acc > REST_W)
                    acc_nxt = acc - WIDTH'(1);
                else if (acc < REST_W)
                    acc_nxt = acc + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            acc <= REST_W;
        else
            acc <= acc_nxt;
    end

    assign value = acc;
endmodule

module axis_ramp_ctrl #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 196850,
    parameter int MAX_VAL  = 254,
    parameter int REST_VAL = 0,
    parameter int INVERT   = 1
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       spring,
    input  logic [CHANNELS-1:0]       use_analog,
    input  logic [CHANNELS*WIDTH-1:0] analog,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min,
    output logic                      tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] pre_cnt;

    // tick is registered so it is high exactly while pre_cnt == TICK_DIV-1
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == CNT_W'(TICK_DIV-1)) ? '0 : pre_cnt + CNT_W'(1);
            tick    <= (pre_cnt == CNT_W'(TICK_DIV-2));
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        axis_ramp_lane #(
            .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .REST_VAL(REST_VAL), .INVERT(INVERT)
        ) u_lane (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .tick      (tick),
            .inc       (inc[ch]),
            .dec       (dec[ch]),
            .spring    (spring[ch]),
            .use_analog(use_analog[ch]),
            .analog    (analog[ch*WIDTH +: WIDTH]),
            .value     (value[ch*WIDTH +: WIDTH])
        );
        assign at_max[ch] = (value[ch*WIDTH +: WIDTH] == WIDTH'(MAX_VAL));
        assign at_min[ch] = (value[ch*WIDTH +: WIDTH] == '0);
    end
endmodule

// File: tb/tb_axis_ramp_ctrl.sv
// Directed bench for axis_ramp_ctrl with an arithmetic reference model checked every cycle.

module tb_axis_ramp_ctrl;
    localparam int CH = 2, W = 8, TD = 4, MAXV = 254, REST = 0;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [CH-1:0]   inc, dec, spring, use_analog;
    logic [CH*W-1:0] analog;
    logic [CH*W-1:0] value;
    logic [CH-1:0]   at_max, at_min;
    logic            tick;

    int checks = 0, errors = 0;
    int mv[CH];
    int hold[CH];
    int hdir[CH];
    int cyc = 0;
    bit cmp_en = 1'b0;

    axis_ramp_ctrl #(
        .CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .MAX_VAL(MAXV), .REST_VAL(REST), .INVERT(1)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .inc(inc), .dec(dec), .spring(spring),
        .use_analog(use_analog), .analog(analog), .value(value),
        .at_max(at_max), .at_min(at_min), .tick(tick)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_tick();
        return (cyc % TD) == TD - 1;
    endfunction

    function automatic int map_analog(input logic [W-1:0] raw);
        logic signed [W-1:0] s;
        int u;
        s = raw;
        u = 255 - (int'(s) + 128);
        return (u > MAXV) ? MAXV : u;
    endfunction

    // reference model: cycles since release decide the tick, plain integer rules do the rest
    always @(posedge clk_sys) begin
        bit tk;
        int st;
        tk = model_tick();
        if (reset) begin
            cyc = 0;
            for (int c = 0; c < CH; c++) begin
                mv[c] = REST; hold[c] = 0; hdir[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (use_analog[c]) begin
                    mv[c] = map_analog(analog[c*W +: W]);
                    hold[c] = 0;
                end else if (tk) begin
                    st = 1;
`ifdef AXIS_RAMP_ACCEL_EN
                    if (hold[c] >= 32) st = 4;
`endif
                    if (inc[c] && !dec[c]) mv[c] = (mv[c] + st > MAXV) ? MAXV : mv[c] + st;
                    else if (dec[c] && !inc[c]) mv[c] = (mv[c] - st < 0) ? 0 : mv[c] - st;
                    else if (!inc[c] && !dec[c] && spring[c]) begin
                        if (mv[c] > REST) mv[c]--;
                        else if (mv[c] < REST) mv[c]++;
                    end
                    if (inc[c] ^ dec[c]) begin
                        if (hold[c] > 0 && hdir[c] == int'(inc[c])) hold[c] = (hold[c] < 32) ? hold[c] + 1 : 32;
                        else hold[c] = 1;
                        hdir[c] = int'(inc[c]);
                    end else hold[c] = 0;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            check("tick", int'(tick), int'(model_tick()));
            for (int c = 0; c < CH; c++) begin
                check($sformatf("value[%0d]", c), int'(value[c*W +: W]), mv[c]);
                check($sformatf("at_max[%0d]", c), int'(at_max[c]), int'(mv[c] == MAXV));
                check($sformatf("at_min[%0d]", c), int'(at_min[c]), int'(mv[c] == 0));
            end
        end
    end

    // returns just after the edge that applies the n-th tick step
    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk_sys);
            if (model_tick()) k++;
        end
        @(posedge clk_sys); #1;
    endtask

    function automatic int v(input int c);
        return int'(value[c*W +: W]);
    endfunction

    initial begin
        int first;
        reset = 1'b1; inc = '0; dec = '0; spring = '0; use_analog = '0; analog = '0;
        @(posedge clk_sys); #1; cmp_en = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;

        first = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_sys);
            if (k == 1) begin
                check("rst value0", v(0), 0);
                check("rst at_min0", int'(at_min[0]), 1);
            end
            if (tick === 1'b1 && first < 0) first = k;
        end
        check("first tick cycle", first, 4);
        @(posedge clk_sys); #1;

        inc[0] = 1'b1;
        wait_ticks(260);
        inc[0] = 1'b0;
        check("ramp top", v(0), 254);
        check("ramp at_max", int'(at_max[0]), 1);
        check("ch1 untouched", v(1), 0);

        dec[0] = 1'b1;
        wait_ticks(244);
        check("down to 10", v(0), 10);
        wait_ticks(15);
        check("floor 0", v(0), 0);
        dec[0] = 1'b0; inc[0] = 1'b1;
        wait_ticks(5);
        dec[0] = 1'b1;
        wait_ticks(3);
        check("inc&dec hold", v(0), 5);

        dec[0] = 1'b0;
        wait_ticks(1);
        inc[0] = 1'b0; spring = 2'b11;
        wait_ticks(1);
        check("spring 6->5", v(0), 5);
        wait_ticks(7);
        check("spring rest", v(0), 0);

        spring = '0; inc[0] = 1'b1;
        wait_ticks(3);
        check("pre-reset 3", v(0), 3);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("mid reset", v(0), 0);
        reset = 1'b0; inc[0] = 1'b0;

        use_analog = 2'b11; analog = {8'h40, 8'h80};
        @(posedge clk_sys); #1;
        check("analog -128", v(0), 254);
        check("analog 64", v(1), 63);
        analog[7:0] = 8'h00;
        @(posedge clk_sys); #1;
        check("analog 0", v(0), 127);
        analog[7:0] = 8'h7F;
        @(posedge clk_sys); #1;
        check("analog 127", v(0), 0);
        analog[7:0] = 8'h00;
        @(posedge clk_sys); #1;

        use_analog = 2'b00; inc[0] = 1'b1;
        wait_ticks(3);
        check("bumpless 130", v(0), 130);
        check("ch1 hold", v(1), 63);
        inc[0] = 1'b0;

`ifdef AXIS_RAMP_ACCEL_EN
        reset = 1'b1;
        @(posedge clk_sys); #1;
        reset = 1'b0; inc[0] = 1'b1;
        wait_ticks(40);
        check("accel 40", v(0), 64);
        inc[0] = 1'b0;
`endif

        repeat (6) @(posedge clk_sys);
        #1 cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
